// File: rtl/data_slice_pkg.sv
// Shared types and sizing helpers for the data_slice sequential splitter.
// Optional zero-slice skipping is enabled with DATA_SLICE_SKIP_ZERO_EN.
package data_slice_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // One extra bit guarantees the top slice carries the sign.
  function automatic int slice_count(input int dw, input int sw);
    return (dw + sw) / sw;
  endfunction

  function automatic int idx_width(input int ns);
    return (ns <= 1) ? 1 : $clog2(ns);
  endfunction

endpackage

// File: rtl/data_slice_ext.sv
// Per-lane sign extension, slice selection by index and per-slice
// all-lane zero flags (purely combinational).
module data_slice_ext
  import data_slice_pkg::*;
#(
  parameter int DN = 6,
  parameter int DW = 22,
  parameter int SW = 8,
  parameter int NS = slice_count(DW, SW),
  parameter int IW = idx_width(NS)
) (
  input  logic [DN*DW-1:0] word,
  input  logic [IW-1:0]    idx,
  output logic [DN*SW-1:0] slice,
  output logic [NS-1:0]    zero
);

  logic [NS*SW-1:0] lane_ext [DN];

  for (genvar i = 0; i < DN; i++) begin : g_ext
    assign lane_ext[i] = {
      {(NS*SW-DW){word[i*DW+DW-1]}},
      word[i*DW +: DW]
    };
  end

  always_comb begin
    slice = '0;
    for (int k = 0; k < NS; k++) begin
      if (idx == IW'(k)) begin
        for (int i = 0; i < DN; i++) begin
          slice[i*SW +: SW] = lane_ext[i][k*SW +: SW];
        end
      end
    end
  end

  always_comb begin
    zero = '1;
    for (int k = 0; k < NS; k++) begin
      for (int i = 0; i < DN; i++) begin
        if (lane_ext[i][k*SW +: SW] != '0) begin
          zero[k] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/data_slice_seq.sv
// Sequential multi-lane splitter: one word in, NS slices out, LSB first.
// Define DATA_SLICE_SKIP_ZERO_EN to drop all-zero non-top slices.
module data_slice_seq
  import data_slice_pkg::*;
#(
  parameter int DN = 6,
  parameter int DW = 22,
  parameter int SW = 8,
  localparam int NS = slice_count(DW, SW),
  localparam int IW = idx_width(NS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [DN*DW-1:0] m_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [DN*SW-1:0] s_data,
  output logic [IW-1:0]    s_idx,
  output logic             s_signed,
  output logic             s_last
);

  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [DN*DW-1:0] word_q;
  logic [DN*DW-1:0] src;
  logic [DN*SW-1:0] slice;
  logic [NS-1:0]    zero;
  logic [IW-1:0]    k_d;
  logic [IW-1:0]    k_first;
  logic [IW-1:0]    k_next;
  logic             accept;
  logic             adv;
  logic             load;

  assign s_valid = (state_q == SEND);
  assign m_ready = (state_q == IDLE)
                 | (s_valid & s_ready & s_last);
  assign accept  = m_valid & m_ready;
  assign adv     = s_valid & s_ready & ~s_last;

  // Slice the incoming word on accept, else the held word.
  assign src = accept ? m_data : word_q;

  data_slice_ext #(
    .DN(DN),
    .DW(DW),
    .SW(SW),
    .NS(NS),
    .IW(IW)
  ) u_ext (
    .word (src),
    .idx  (k_d),
    .slice(slice),
    .zero (zero)
  );

`ifdef DATA_SLICE_SKIP_ZERO_EN
  function automatic logic [IW-1:0] pick(
    input logic [NS-1:0] z,
    input int            start
  );
    logic [IW-1:0] r;
    logic          hit;
    r   = LAST;
    hit = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (!hit && k >= start &&
          (k == NS - 1 || !z[k])) begin
        r   = IW'(k);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  assign k_first = pick(zero, 0);
  assign k_next  = pick(zero, int'(s_idx) + 1);
`else
  logic unused_zero;
  assign unused_zero = ^zero;
  assign k_first = '0;
  assign k_next  = s_idx + IW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = s_idx;
    unique case (state_q)
      IDLE: begin
        if (m_valid) begin
          state_d = SEND;
          k_d     = k_first;
        end
      end
      SEND: begin
        if (s_ready) begin
          if (!s_last) begin
            k_d = k_next;
          end else if (m_valid) begin
            k_d = k_first;
          end else begin
            state_d = IDLE;
            k_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load = (state_d == SEND) & (accept | adv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      s_data   <= '0;
      s_idx    <= '0;
      s_signed <= 1'b0;
      s_last   <= 1'b0;
    end else begin
      if (accept) begin
        word_q <= m_data;
      end
      if (load) begin
        s_data   <= slice;
        s_idx    <= k_d;
        s_signed <= (k_d == LAST);
        s_last   <= (k_d == LAST);
      end else if (state_d == IDLE) begin
        s_data   <= '0;
        s_idx    <= '0;
        s_signed <= 1'b0;
        s_last   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_slice_seq.sv
// Directed bench for data_slice_seq with DN=2, DW=22, SW=8 (NS=3).
// Skip-zero expectations follow DATA_SLICE_SKIP_ZERO_EN.
module tb_data_slice_seq;

  localparam int DN = 2;
  localparam int DW = 22;
  localparam int SW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_valid;
  logic             m_ready;
  logic [DN*DW-1:0] m_data;
  logic             s_valid;
  logic             s_ready;
  logic [DN*SW-1:0] s_data;
  logic [1:0]       s_idx;
  logic             s_signed;
  logic             s_last;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [43:0] W_BASIC = {22'h012345, 22'h3FFFFF};
  localparam logic [43:0] W1      = {22'h012345, 22'h2ABCDE};
  localparam logic [43:0] W2      = {22'h3F0F0F, 22'h000111};
  localparam logic [43:0] W_SKIP  = {22'h000200, 22'h000100};
  localparam logic [43:0] W_ZERO  = '0;

  always #5 clk = ~clk;

  data_slice_seq #(
    .DN(DN),
    .DW(DW),
    .SW(SW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_idx   (s_idx),
    .s_signed(s_signed),
    .s_last  (s_last)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic beat(
    input string       tag,
    input logic [1:0]  ix,
    input logic [15:0] dv
  );
    check({tag, ".valid"}, 32'(s_valid), 32'd1);
    check({tag, ".idx"}, 32'(s_idx), 32'(ix));
    check({tag, ".data"}, 32'(s_data), 32'(dv));
    check({tag, ".last"}, 32'(s_last), 32'(ix == 2'd2));
    check({tag, ".sgn"}, 32'(s_signed), 32'(ix == 2'd2));
  endtask

  // Expected beats packed LSB-first: idx b at ixs[2b+:2], data at dvs[16b+:16].
  task automatic send_word(
    input string       tag,
    input logic [43:0] w,
    input int          n,
    input logic [5:0]  ixs,
    input logic [47:0] dvs
  );
    m_valid = 1'b1;
    m_data  = w;
    @(negedge clk);
    m_valid = 1'b0;
    for (int b = 0; b < n; b++) begin
      beat($sformatf("%s.b%0d", tag, b), ixs[b*2 +: 2], dvs[b*16 +: 16]);
      @(negedge clk);
    end
    check({tag, ".idle"}, 32'(s_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    m_valid = 1'b1;
    m_data  = W_BASIC;
    s_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.valid", 32'(s_valid), 32'd0);
    check("rst.data", 32'(s_data), 32'd0);
    check("rst.idx", 32'(s_idx), 32'd0);
    check("rst.sgn", 32'(s_signed), 32'd0);
    check("rst.last", 32'(s_last), 32'd0);
    check("rst.mrdy", 32'(m_ready), 32'd1);

    // First word after release: basic split.
    rst_n = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    beat("basic0", 2'd0, 16'h45FF);
    @(negedge clk);
    beat("basic1", 2'd1, 16'h23FF);
    @(negedge clk);
    beat("basic2", 2'd2, 16'h01FF);
    @(negedge clk);
    check("basic.idle", 32'(s_valid), 32'd0);

    // Back-to-back words.
    m_valid = 1'b1;
    m_data  = W1;
    @(negedge clk);
    m_data = W2;
    beat("b2b.a0", 2'd0, 16'h45DE);
    check("b2b.a0.mrdy", 32'(m_ready), 32'd0);
    @(negedge clk);
    beat("b2b.a1", 2'd1, 16'h23BC);
    @(negedge clk);
    beat("b2b.a2", 2'd2, 16'h01EA);
    check("b2b.a2.mrdy", 32'(m_ready), 32'd1);
    @(negedge clk);
    m_valid = 1'b0;
    beat("b2b.b0", 2'd0, 16'h0F11);
    @(negedge clk);
    beat("b2b.b1", 2'd1, 16'h0F01);
    @(negedge clk);
    beat("b2b.b2", 2'd2, 16'hFF00);
    @(negedge clk);
    check("b2b.idle", 32'(s_valid), 32'd0);

    // Backpressure on idx 1 with a second word waiting.
    m_valid = 1'b1;
    m_data  = W1;
    @(negedge clk);
    m_data = W2;
    beat("bp.a0", 2'd0, 16'h45DE);
    @(negedge clk);
    s_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      beat($sformatf("bp.hold%0d", c), 2'd1, 16'h23BC);
      check($sformatf("bp.mrdy%0d", c), 32'(m_ready), 32'd0);
      @(negedge clk);
    end
    s_ready = 1'b1;
    beat("bp.a1", 2'd1, 16'h23BC);
    check("bp.a1.mrdy", 32'(m_ready), 32'd0);
    @(negedge clk);
    beat("bp.a2", 2'd2, 16'h01EA);
    check("bp.a2.mrdy", 32'(m_ready), 32'd1);
    @(negedge clk);
    m_valid = 1'b0;
    beat("bp.b0", 2'd0, 16'h0F11);
    @(negedge clk);
    beat("bp.b1", 2'd1, 16'h0F01);
    @(negedge clk);
    beat("bp.b2", 2'd2, 16'hFF00);
    @(negedge clk);
    check("bp.idle", 32'(s_valid), 32'd0);

`ifdef DATA_SLICE_SKIP_ZERO_EN
    send_word("skip", W_SKIP, 2,
              {2'd0, 2'd2, 2'd1},
              {16'h0000, 16'h0000, 16'h0201});
    send_word("zero", W_ZERO, 1,
              {2'd0, 2'd0, 2'd2},
              {16'h0000, 16'h0000, 16'h0000});
`else
    send_word("skip", W_SKIP, 3,
              {2'd2, 2'd1, 2'd0},
              {16'h0000, 16'h0201, 16'h0000});
    send_word("zero", W_ZERO, 3,
              {2'd2, 2'd1, 2'd0},
              {16'h0000, 16'h0000, 16'h0000});
`endif

    // Reset in the middle of a word.
    m_valid = 1'b1;
    m_data  = W1;
    @(negedge clk);
    m_valid = 1'b0;
    beat("mid.a0", 2'd0, 16'h45DE);
    @(negedge clk);
    beat("mid.a1", 2'd1, 16'h23BC);
    rst_n = 1'b0;
    #1;
    check("mid.rst.valid", 32'(s_valid), 32'd0);
    check("mid.rst.idx", 32'(s_idx), 32'd0);
    check("mid.rst.mrdy", 32'(m_ready), 32'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    m_valid = 1'b1;
    m_data  = W2;
    @(negedge clk);
    m_valid = 1'b0;
    beat("mid.b0", 2'd0, 16'h0F11);
    @(negedge clk);
    beat("mid.b1", 2'd1, 16'h0F01);
    @(negedge clk);
    beat("mid.b2", 2'd2, 16'hFF00);
    @(negedge clk);
    check("mid.idle", 32'(s_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
